// File: rtl/ctrl_pkg.sv
// Shared constants for the multi-cycle MIPS control path: state codes,
// opcodes, ALUOp codes and datapath mux select codes.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MADDR   = 4'd2,
    S_MRD     = 4'd3,
    S_LWWB    = 4'd4,
    S_MWR     = 4'd5,
    S_REXEC   = 4'd6,
    S_RWB     = 4'd7,
    S_BEQ     = 4'd8,
    S_JUMP    = 4'd9,
    S_IEXEC   = 4'd10,
    S_IWB     = 4'd11,
    S_ILLEGAL = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/ctrl_out_decode.sv
// Combinational decode of the control state into datapath enables and selects.
// Enables that change architectural state are held low while reset is asserted.
module ctrl_out_decode
  import ctrl_pkg::*;
(
  input  logic [3:0] state,
  input  logic       mem_ready,
  input  logic       rst_n,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSource,
  output logic [1:0] ALUOp,
  output logic       illegal_op,
  output logic       instr_done
);

  logic pc_write_raw, pc_write_cond_raw, mem_read_raw, mem_write_raw;
  logic ir_write_raw, reg_write_raw, illegal_raw, done_raw;

  always_comb begin
    // NOTE: every output gets a default before the case so no path infers a latch.
    pc_write_raw      = 1'b0;
    pc_write_cond_raw = 1'b0;
    mem_read_raw      = 1'b0;
    mem_write_raw     = 1'b0;
    ir_write_raw      = 1'b0;
    reg_write_raw     = 1'b0;
    illegal_raw       = 1'b0;
    done_raw          = 1'b0;
    IorD              = 1'b0;
    MemtoReg          = 1'b0;
    RegDst            = 1'b0;
    ALUSrcA           = 1'b0;
    ALUSrcB           = SRCB_B;
    PCSource          = PCSRC_ALU;
    ALUOp             = ALUOP_ADD;

    case (state)
      S_FETCH: begin
        mem_read_raw = 1'b1;
        ALUSrcB      = SRCB_FOUR;
        ir_write_raw = mem_ready;
        pc_write_raw = mem_ready;
      end
      S_DECODE: ALUSrcB = SRCB_IMM_SH2;
      S_MADDR, S_IEXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
      end
      S_MRD: begin
        mem_read_raw = 1'b1;
        IorD         = 1'b1;
      end
      S_LWWB: begin
        reg_write_raw = 1'b1;
        MemtoReg      = 1'b1;
        done_raw      = 1'b1;
      end
      S_MWR: begin
        mem_write_raw = 1'b1;
        IorD          = 1'b1;
        done_raw      = mem_ready;
      end
      S_REXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = ALUOP_FUNCT;
      end
      S_RWB: begin
        reg_write_raw = 1'b1;
        RegDst        = 1'b1;
        done_raw      = 1'b1;
      end
      S_BEQ: begin
        ALUSrcA           = 1'b1;
        ALUOp             = ALUOP_SUB;
        pc_write_cond_raw = 1'b1;
        PCSource          = PCSRC_ALUOUT;
        done_raw          = 1'b1;
      end
      S_JUMP: begin
        pc_write_raw = 1'b1;
        PCSource     = PCSRC_JUMP;
        done_raw     = 1'b1;
      end
      S_IWB: begin
        reg_write_raw = 1'b1;
        done_raw      = 1'b1;
      end
      S_ILLEGAL: illegal_raw = 1'b1;
      default: ;
    endcase
  end

  assign PCWrite     = pc_write_raw      & rst_n;
  assign PCWriteCond = pc_write_cond_raw & rst_n;
  assign MemRead     = mem_read_raw      & rst_n;
  assign MemWrite    = mem_write_raw     & rst_n;
  assign IRWrite     = ir_write_raw      & rst_n;
  assign RegWrite    = reg_write_raw     & rst_n;
  assign illegal_op  = illegal_raw       & rst_n;
  assign instr_done  = done_raw          & rst_n;

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Main control FSM of the multi-cycle MIPS datapath: state register and
// opcode-driven next-state logic; output decode lives in ctrl_out_decode.
module multi_cycle_ctrl
  import ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  input  logic       zero,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSource,
  output logic [1:0] ALUOp,
  output logic       illegal_op,
  output logic       instr_done,
  output logic [3:0] state
);

  state_t state_q, state_d;

  // The branch decision is made in the datapath from zero and PCWriteCond.
  logic unused_zero;
  assign unused_zero = zero;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so all flops update together.
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MADDR;
          OP_RTYPE:     state_d = S_REXEC;
          OP_BEQ:       state_d = S_BEQ;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_IEXEC;
          default:      state_d = S_ILLEGAL;
        endcase
      end
      S_MADDR:  state_d = (opcode == OP_SW) ? S_MWR : S_MRD;
      S_MRD:    state_d = mem_ready ? S_LWWB : S_MRD;
      S_MWR:    state_d = mem_ready ? S_FETCH : S_MWR;
      S_REXEC:  state_d = S_RWB;
      S_IEXEC:  state_d = S_IWB;
      // Final states and the unreachable codes 13-15 all return to fetch.
      default:  state_d = S_FETCH;
    endcase
  end

  assign state = state_q;

  ctrl_out_decode u_decode (
    .state       (state_q),
    .mem_ready   (mem_ready),
    .rst_n       (rst_n),
    .PCWrite     (PCWrite),
    .PCWriteCond (PCWriteCond),
    .IorD        (IorD),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .IRWrite     (IRWrite),
    .MemtoReg    (MemtoReg),
    .RegWrite    (RegWrite),
    .RegDst      (RegDst),
    .ALUSrcA     (ALUSrcA),
    .ALUSrcB     (ALUSrcB),
    .PCSource    (PCSource),
    .ALUOp       (ALUOp),
    .illegal_op  (illegal_op),
    .instr_done  (instr_done)
  );

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Self-checking bench for multi_cycle_ctrl: directed cycle table for the
// documented sequences, then random instructions against a plan-based model.
module tb_multi_cycle_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       zero;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, RegWrite, RegDst, ALUSrcA;
  logic [1:0] ALUSrcB, PCSource, ALUOp;
  logic       illegal_op, instr_done;
  logic [3:0] state;

  int checks = 0;
  int errors = 0;

  multi_cycle_ctrl dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready), .zero(zero),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .RegDst(RegDst), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSource(PCSource),
    .ALUOp(ALUOp), .illegal_op(illegal_op), .instr_done(instr_done), .state(state)
  );

  always #5 clk = ~clk;

  localparam logic [5:0] R = 6'b000000, LW = 6'b100011, SW = 6'b101011;
  localparam logic [5:0] BQ = 6'b000100, JP = 6'b000010, AI = 6'b001000, BAD = 6'b111111;

  // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,MemtoReg,RegWrite,
  //  RegDst,ALUSrcA,ALUSrcB,PCSource,ALUOp,illegal_op,instr_done}
  logic [17:0] dut_ctrl;
  assign dut_ctrl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                     RegWrite, RegDst, ALUSrcA, ALUSrcB, PCSource, ALUOp, illegal_op,
                     instr_done};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected control word for a state, written from the per-state table of controls.
  function automatic logic [17:0] model_ctrl(input int st, input logic mr, input logic rn);
    logic pcw, pcwc, iord, mrd, mwr, irw, m2r, rw, rdst, srca, ill, done;
    logic [1:0] srcb, pcs, aop;
    {pcw, pcwc, iord, mrd, mwr, irw, m2r, rw, rdst, srca, ill, done} = '0;
    srcb = 2'b00; pcs = 2'b00; aop = 2'b00;
    case (st)
      0:  begin mrd = 1; srcb = 2'b01; irw = mr; pcw = mr; end
      1:  srcb = 2'b11;
      2:  begin srca = 1; srcb = 2'b10; end
      3:  begin mrd = 1; iord = 1; end
      4:  begin rw = 1; m2r = 1; done = 1; end
      5:  begin mwr = 1; iord = 1; done = mr; end
      6:  begin srca = 1; aop = 2'b10; end
      7:  begin rw = 1; rdst = 1; done = 1; end
      8:  begin srca = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; done = 1; end
      9:  begin pcw = 1; pcs = 2'b10; done = 1; end
      10: begin srca = 1; srcb = 2'b10; end
      11: begin rw = 1; done = 1; end
      12: ill = 1;
      default: ;
    endcase
    if (!rn) {pcw, pcwc, mrd, mwr, irw, rw, ill, done} = '0;
    return {pcw, pcwc, iord, mrd, mwr, irw, m2r, rw, rdst, srca, srcb, pcs, aop, ill, done};
  endfunction

  // State path of an instruction when memory never stalls.
  function automatic void build_plan(input logic [5:0] op, output int p[$]);
    case (op)
      R:       p = '{0, 1, 6, 7};
      LW:      p = '{0, 1, 2, 3, 4};
      SW:      p = '{0, 1, 2, 5};
      BQ:      p = '{0, 1, 8};
      JP:      p = '{0, 1, 9};
      AI:      p = '{0, 1, 10, 11};
      default: p = '{0, 1, 12};
    endcase
  endfunction

  typedef struct {
    logic       rn;
    logic [5:0] op;
    logic       mr;
    int         st;
    logic [3:0] key;   // {RegWrite, instr_done, illegal_op, IRWrite}
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(input logic rn, input logic [5:0] op, input logic mr,
                             input int st, input logic [3:0] key);
    vec_t t;
    t.rn = rn; t.op = op; t.mr = mr; t.st = st; t.key = key;
    return t;
  endfunction

  initial begin
    int plan[$];
    int idx;
    logic [5:0] cur_op;
    logic rn, mr;
    int exp_st;
    int done_cnt, ill_cnt;

    zero = 1'b0; rst_n = 1'b0; opcode = R; mem_ready = 1'b1;
    @(posedge clk);

    // Reset, R-type
    vecs.push_back(v(0, R,  1, 0,  4'b0000));
    vecs.push_back(v(1, R,  1, 0,  4'b0001));
    vecs.push_back(v(1, R,  1, 1,  4'b0000));
    vecs.push_back(v(1, R,  1, 6,  4'b0000));
    vecs.push_back(v(1, R,  1, 7,  4'b1100));
    // lw with 2 fetch stalls and 1 read stall: 8 cycles
    vecs.push_back(v(1, LW, 0, 0,  4'b0000));
    vecs.push_back(v(1, LW, 0, 0,  4'b0000));
    vecs.push_back(v(1, LW, 1, 0,  4'b0001));
    vecs.push_back(v(1, LW, 1, 1,  4'b0000));
    vecs.push_back(v(1, LW, 1, 2,  4'b0000));
    vecs.push_back(v(1, LW, 0, 3,  4'b0000));
    vecs.push_back(v(1, LW, 1, 3,  4'b0000));
    vecs.push_back(v(1, LW, 1, 4,  4'b1100));
    // sw then beq
    vecs.push_back(v(1, SW, 1, 0,  4'b0001));
    vecs.push_back(v(1, SW, 1, 1,  4'b0000));
    vecs.push_back(v(1, SW, 1, 2,  4'b0000));
    vecs.push_back(v(1, SW, 1, 5,  4'b0100));
    vecs.push_back(v(1, BQ, 1, 0,  4'b0001));
    vecs.push_back(v(1, BQ, 1, 1,  4'b0000));
    vecs.push_back(v(1, BQ, 1, 8,  4'b0100));
    // j and addi
    vecs.push_back(v(1, JP, 1, 0,  4'b0001));
    vecs.push_back(v(1, JP, 1, 1,  4'b0000));
    vecs.push_back(v(1, JP, 1, 9,  4'b0100));
    vecs.push_back(v(1, AI, 1, 0,  4'b0001));
    vecs.push_back(v(1, AI, 1, 1,  4'b0000));
    vecs.push_back(v(1, AI, 1, 10, 4'b0000));
    vecs.push_back(v(1, AI, 1, 11, 4'b1100));
    // illegal opcode
    vecs.push_back(v(1, BAD, 1, 0,  4'b0001));
    vecs.push_back(v(1, BAD, 1, 1,  4'b0000));
    vecs.push_back(v(1, BAD, 1, 12, 4'b0010));
    // reset during MRD aborts the lw, then a clean lw
    vecs.push_back(v(1, LW, 1, 0,  4'b0001));
    vecs.push_back(v(1, LW, 1, 1,  4'b0000));
    vecs.push_back(v(1, LW, 1, 2,  4'b0000));
    vecs.push_back(v(0, LW, 1, 3,  4'b0000));
    vecs.push_back(v(1, LW, 1, 0,  4'b0001));
    vecs.push_back(v(1, LW, 1, 1,  4'b0000));
    vecs.push_back(v(1, LW, 1, 2,  4'b0000));
    vecs.push_back(v(1, LW, 1, 3,  4'b0000));
    vecs.push_back(v(1, LW, 1, 4,  4'b1100));

    foreach (vecs[i]) begin
      @(negedge clk);
      rst_n = vecs[i].rn; opcode = vecs[i].op; mem_ready = vecs[i].mr;
      #1;
      check($sformatf("dir%0d state", i), 32'(state), 32'(vecs[i].st));
      check($sformatf("dir%0d key", i), 32'({RegWrite, instr_done, illegal_op, IRWrite}),
            32'(vecs[i].key));
      check($sformatf("dir%0d ctrl", i), 32'(dut_ctrl),
            32'(model_ctrl(vecs[i].st, vecs[i].mr, vecs[i].rn)));
    end

    // Random instructions with random memory stalls and occasional resets.
    idx = 0;
    cur_op = R;
    plan = '{};
    done_cnt = 0; ill_cnt = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (idx == 0) begin
        case ($urandom_range(0, 7))
          0: cur_op = R;  1: cur_op = LW; 2: cur_op = SW; 3: cur_op = BQ;
          4: cur_op = JP; 5: cur_op = AI; 6: cur_op = BAD;
          default: cur_op = 6'($urandom);
        endcase
        build_plan(cur_op, plan);
      end
      rn = ($urandom_range(0, 149) != 0);
      mr = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      rst_n = rn; opcode = cur_op; mem_ready = mr;
      #1;
      exp_st = plan[idx];
      check($sformatf("rnd%0d state", cyc), 32'(state), 32'(exp_st));
      check($sformatf("rnd%0d ctrl", cyc), 32'(dut_ctrl), 32'(model_ctrl(exp_st, mr, rn)));
      if (instr_done && illegal_op) begin
        errors++;
        $display("FAIL rnd%0d done_and_illegal: both asserted", cyc);
      end
      if (instr_done) done_cnt++;
      if (illegal_op) ill_cnt++;
      if (!rn) idx = 0;
      else if ((exp_st == 0 || exp_st == 3 || exp_st == 5) && !mr) idx = idx;
      else begin
        idx++;
        if (idx == plan.size()) begin
          idx = 0;
          check($sformatf("rnd%0d one_pulse", cyc), 32'(done_cnt + ill_cnt), 32'd1);
          done_cnt = 0; ill_cnt = 0;
        end
      end
      if (idx == 0) begin done_cnt = 0; ill_cnt = 0; end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
